// File: rtl/vga_pkg.sv
// Shared VGA stream types and board-label geometry, used by the text overlay
// and by the char_addr generator so both agree on where glyphs live.
package vga_pkg;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  localparam int GLYPH_W = 8;

  // Letter labels: one glyph per 64-pixel board column, above and below the board
  localparam logic [10:0] LETTER_X_MIN     = 11'd256;
  localparam logic [10:0] LETTER_X_MAX     = 11'd768;
  localparam logic [10:0] LETTER_Y_TOP_MIN = 11'd104;
  localparam logic [10:0] LETTER_Y_TOP_MAX = 11'd120;
  localparam logic [10:0] LETTER_Y_BOT_MIN = 11'd648;
  localparam logic [10:0] LETTER_Y_BOT_MAX = 11'd664;
  localparam logic [5:0]  LETTER_COL_MIN   = 6'd28;
  localparam logic [5:0]  LETTER_COL_MAX   = 6'd35;

  // Number labels: one glyph per 64-pixel board row, left and right of the board
  localparam logic [10:0] NUM_X_LEFT  = 11'd236;
  localparam logic [10:0] NUM_X_RIGHT = 11'd780;
  localparam logic [10:0] NUM_Y_MIN   = 11'd128;
  localparam logic [10:0] NUM_Y_MAX   = 11'd640;
  localparam logic [5:0]  NUM_ROW_MIN = 6'd24;
  localparam logic [5:0]  NUM_ROW_MAX = 6'd40;

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between drawing stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/delay_vga.sv
// N-stage register chain over a VGA beat plus a side-band user field.
module delay_vga
  import vga_pkg::*;
#(
  parameter int N      = 1,
  parameter int USER_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  vga_t              d,
  input  logic [USER_W-1:0] user_d,
  output vga_t              q,
  output logic [USER_W-1:0] user_q
);

  vga_t [N-1:0]              stage;
  logic [N-1:0][USER_W-1:0]  ustage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage  <= '0;
      ustage <= '0;
    end else begin
      stage[0]  <= d;
      ustage[0] <= user_d;
      for (int i = 1; i < N; i++) begin
        stage[i]  <= stage[i-1];
        ustage[i] <= ustage[i-1];
      end
    end
  end

  assign q      = stage[N-1];
  assign user_q = ustage[N-1];

endmodule

// File: rtl/draw_letters.sv
// Board-label text overlay: finds the glyph column for each pixel, waits out the
// font ROM latency alongside the VGA stream, then paints TEXT_COLOR on set bits.
module draw_letters
  import vga_pkg::*;
#(
  parameter int          ROM_LATENCY = 1,
  parameter logic [11:0] TEXT_COLOR  = 12'h000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_pixels,
  vga_if.in          vga_in,
  vga_if.out         vga_out
);

  logic [5:0]  hmod, vmod;
  logic [10:0] dl, dr;
  logic        letter_hit, num_row;
  logic        in_text;
  logic [2:0]  col;

  assign hmod = vga_in.hcount[5:0];
  assign vmod = vga_in.vcount[5:0];
  assign dl   = vga_in.hcount - NUM_X_LEFT;
  assign dr   = vga_in.hcount - NUM_X_RIGHT;

  assign letter_hit = (vga_in.hcount >= LETTER_X_MIN) && (vga_in.hcount <= LETTER_X_MAX) &&
                      (((vga_in.vcount >= LETTER_Y_TOP_MIN) && (vga_in.vcount <= LETTER_Y_TOP_MAX)) ||
                       ((vga_in.vcount >= LETTER_Y_BOT_MIN) && (vga_in.vcount <= LETTER_Y_BOT_MAX))) &&
                      (hmod >= LETTER_COL_MIN) && (hmod <= LETTER_COL_MAX);

  assign num_row = (vga_in.vcount >= NUM_Y_MIN) && (vga_in.vcount <= NUM_Y_MAX) &&
                   (vmod >= NUM_ROW_MIN) && (vmod <= NUM_ROW_MAX);

  // Number fields are GLYPH_W+1 wide; the extra 9th column stays blank because
  // only offsets below GLYPH_W are accepted.
  always_comb begin
    in_text = 1'b0;
    col     = 3'd0;
    if (letter_hit) begin
      in_text = 1'b1;
      col     = 3'(hmod - LETTER_COL_MIN);
    end else if (num_row && (vga_in.hcount >= NUM_X_LEFT) && (dl < 11'(GLYPH_W))) begin
      in_text = 1'b1;
      col     = 3'(dl);
    end else if (num_row && (vga_in.hcount >= NUM_X_RIGHT) && (dr < 11'(GLYPH_W))) begin
      in_text = 1'b1;
      col     = 3'(dr);
    end
  end

  vga_t       cur, dly;
  logic [3:0] user_d;
  logic       in_text_d;
  logic [2:0] col_d;
  logic       glyph_bit, overlay;

  assign cur = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                 hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                 hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                 rgb:    vga_in.rgb};

  delay_vga #(.N(ROM_LATENCY), .USER_W(4)) u_dly (
    .clk    (clk),
    .rst_n  (rst),
    .d      (cur),
    .user_d ({in_text, col}),
    .q      (dly),
    .user_q (user_d)
  );

  assign in_text_d = user_d[3];
  assign col_d     = user_d[2:0];
  assign glyph_bit = char_pixels[3'd7 - col_d];
  // in_text_d gates the ROM byte so whatever address 0 holds never shows up
  assign overlay   = in_text_d & glyph_bit & ~dly.hblnk & ~dly.vblnk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= dly.hcount;
      vga_out.vcount <= dly.vcount;
      vga_out.hsync  <= dly.hsync;
      vga_out.vsync  <= dly.vsync;
      vga_out.hblnk  <= dly.hblnk;
      vga_out.vblnk  <= dly.vblnk;
      vga_out.rgb    <= overlay ? TEXT_COLOR : dly.rgb;
    end
  end

endmodule

// File: tb/tb_draw_letters.sv
// Directed vectors plus a line sweep for draw_letters at ROM latency 1 and 3.
module tb_draw_letters;
  import vga_pkg::*;

  localparam logic [11:0] TC = 12'hF00;
  localparam logic [11:0] UP = 12'h5A5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cp1 = 8'h00;
  logic [7:0] cp3 = 8'h00;

  always #5 clk = ~clk;

  vga_if vin();
  vga_if vo1();
  vga_if vo3();

  draw_letters #(.ROM_LATENCY(1), .TEXT_COLOR(TC)) dut1 (
    .clk(clk), .rst(rst), .char_pixels(cp1), .vga_in(vin.in), .vga_out(vo1.out));
  draw_letters #(.ROM_LATENCY(3), .TEXT_COLOR(TC)) dut3 (
    .clk(clk), .rst(rst), .char_pixels(cp3), .vga_in(vin.in), .vga_out(vo3.out));

  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [7:0]  rom;
    logic [11:0] exp;
  } vec_t;

  vec_t hist[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [37:0] obs1();
    return {vo1.hcount, vo1.vcount, vo1.hsync, vo1.vsync, vo1.hblnk, vo1.vblnk, vo1.rgb};
  endfunction

  function automatic logic [37:0] obs3();
    return {vo3.hcount, vo3.vcount, vo3.hsync, vo3.vsync, vo3.hblnk, vo3.vblnk, vo3.rgb};
  endfunction

  function automatic logic [37:0] want(vec_t x);
    return {x.h, x.v, x.hs, x.vs, x.hb, x.vb, x.exp};
  endfunction

  task automatic chk(input string name, input int idx, input logic [37:0] act, input logic [37:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, req);
    end
  endtask

  // Independent reference for the overlay colour of one pixel
  function automatic logic [11:0] model(vec_t x);
    int h = int'(x.h);
    int v = int'(x.v);
    int c = -1;
    if (h >= 256 && h <= 768 && ((v >= 104 && v <= 120) || (v >= 648 && v <= 664)) &&
        (h % 64) >= 28 && (h % 64) <= 35)
      c = (h % 64) - 28;
    else if (v >= 128 && v <= 640 && (v % 64) >= 24 && (v % 64) <= 40) begin
      if (h >= 236 && h <= 243) c = h - 236;
      else if (h >= 780 && h <= 787) c = h - 780;
    end
    if (c >= 0 && x.rom[7-c] && !x.hb && !x.vb) return TC;
    return x.rgb;
  endfunction

  function automatic vec_t tv(int h, int v, bit hb, bit vb, bit hs, logic [11:0] rgb,
                              logic [7:0] rom, logic [11:0] exp);
    vec_t x;
    x.h = 11'(h); x.v = 11'(v); x.hb = hb; x.vb = vb; x.hs = hs; x.vs = vb;
    x.rgb = rgb; x.rom = rom; x.exp = exp;
    return x;
  endfunction

  function automatic vec_t mk(int h, int v);
    vec_t x;
    logic [10:0] hh, vv;
    hh = 11'(h); vv = 11'(v);
    x.h = hh; x.v = vv;
    x.hb = (h >= 1024);
    x.hs = (h >= 1048 && h < 1184);
    x.vb = (v >= 768);
    x.vs = (v >= 771 && v < 777);
    x.rgb = (x.hb || x.vb) ? 12'h000 : {hh[5:2] ^ vv[3:0], vv[7:4], hh[9:6]} | 12'h010;
    x.rom = 8'(((h >> 6) * 29) ^ (v * 7) ^ 8'h96);
    x.exp = model(x);
    return x;
  endfunction

  // One pixel clock: check the outputs owed from earlier pixels, then drive the
  // next pixel and the ROM bytes each latency expects now.
  task automatic cycle(input vec_t x);
    int j;
    @(negedge clk);
    if (!rst) rst = 1'b1;
    j = hist.size();
    if (j >= 2) chk("lat1_px", j - 2, obs1(), want(hist[j-2]));
    else        chk("lat1_fill", j, obs1(), '0);
    if (j >= 4) chk("lat3_px", j - 4, obs3(), want(hist[j-4]));
    else        chk("lat3_fill", j, obs3(), '0);
    vin.hcount = x.h;  vin.vcount = x.v;
    vin.hsync  = x.hs; vin.vsync  = x.vs;
    vin.hblnk  = x.hb; vin.vblnk  = x.vb;
    vin.rgb    = x.rgb;
    hist.push_back(x);
    cp1 = (j >= 1) ? hist[j-1].rom : 8'hFF;
    cp3 = (j >= 3) ? hist[j-3].rom : 8'hFF;
  endtask

  // Assert reset mid-stream with random traffic; output must drop to zero at once
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst1_now", 0, obs1(), '0);
    chk("rst3_now", 0, obs3(), '0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      vin.hcount = 11'($urandom); vin.vcount = 11'($urandom);
      vin.hsync = 1'($urandom); vin.vsync = 1'($urandom);
      vin.hblnk = 1'($urandom); vin.vblnk = 1'($urandom);
      vin.rgb = 12'($urandom); cp1 = 8'($urandom); cp3 = 8'($urandom);
      #1;
      chk("rst1_hold", k, obs1(), '0);
      chk("rst3_hold", k, obs3(), '0);
    end
    hist.delete();
  endtask

  initial begin
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
    vin.hblnk = 0; vin.vblnk = 0; vin.rgb = '0;

    // Directed table
    for (int h = 284; h <= 291; h++)
      tbl.push_back(tv(h, 110, 0, 0, 0, UP, 8'h81, (h == 284 || h == 291) ? TC : UP));
    for (int h = 236; h <= 244; h++)
      tbl.push_back(tv(h, 154, 0, 0, 0, UP, 8'hFF, (h <= 243) ? TC : UP));
    tbl.push_back(tv(787, 154, 0, 0, 0, UP, 8'h01, TC));
    tbl.push_back(tv(788, 154, 0, 0, 0, UP, 8'hFF, UP));
    tbl.push_back(tv(780, 154, 0, 0, 0, UP, 8'h7F, UP));
    tbl.push_back(tv(300, 300, 0, 0, 0, UP, 8'hFF, UP));
    tbl.push_back(tv(283, 110, 0, 0, 0, UP, 8'hFF, UP));
    tbl.push_back(tv(292, 110, 0, 0, 0, UP, 8'hFF, UP));
    tbl.push_back(tv(732, 648, 0, 0, 0, UP, 8'h80, TC));
    tbl.push_back(tv(284, 110, 1, 0, 1, UP, 8'hFF, UP));
    tbl.push_back(tv(290, 110, 0, 1, 0, UP, 8'hFF, UP));
    tbl.push_back(tv(100,  50, 0, 0, 0, UP, 8'hFF, UP));
    tbl.push_back(tv(240, 152, 0, 0, 0, UP, 8'hFF, TC));
    tbl.push_back(tv(240, 170, 0, 0, 0, UP, 8'hFF, UP));

    do_reset(4);
    foreach (tbl[i]) cycle(tbl[i]);

    // Line sweep with per-pixel ROM bytes; reset lands mid-line once
    begin
      int lines[8] = '{103, 110, 120, 121, 152, 154, 664, 770};
      foreach (lines[li]) begin
        for (int h = 0; h < 1344; h++) begin
          if (lines[li] == 154 && h == 600) do_reset(3);
          cycle(mk(h, lines[li]));
        end
      end
    end
    for (int k = 0; k < 4; k++) cycle(mk(1200, 800));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_letters.md
Name: draw_letters

Overview:
- Consumer end of the board-label character path.
- Takes the font ROM row byte fetched for the current char_addr, picks the glyph bit for the current pixel, and overlays TEXT_COLOR on the VGA stream.
- Delays all VGA timing and rgb signals so they stay aligned with the ROM read latency.
- Sits between the chessboard/background drawing stage and the next overlay stage; it drives the ROM's address consumer side in parallel with the char_addr generator.

Parameters:
- ROM_LATENCY, 1: clock cycles from char_addr presentation to valid char_pixels; legal range 1..4.
- TEXT_COLOR, 12'h000: rgb written on glyph pixels set to 1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- char_pixels  in  8  font row byte from the ROM; bit 7 = leftmost column.
- vga_in  vga_if.in  -  upstream timing (hcount, vcount, hsync, vsync, hblnk, vblnk) and rgb.
- vga_out  vga_if.out  -  delayed timing with rgb overlaid.

Behaviour:
- Reset (rst=0, async): every vga_out field = 0; all pipeline stages cleared; valid pixels resume ROM_LATENCY+1 cycles after release.
- Stage 0 (combinational on vga_in), text-region detection with vga_pkg constants:
  - Letter band: hcount 256..768 AND (vcount 104..120 OR 648..664) AND hcount%64 in 28..35. Column = hcount%64 - 28.
  - Number band: vcount 128..640 AND vcount%64 in 24..40 AND hcount 236..244 (column = hcount - 236) or hcount 780..788 (column = hcount - 780).
  - Column 8 (9th pixel of a number field) is forced blank.
  - Letter band has priority when both match.
  - Output of stage 0: in_text (1 bit) and col (3 bits); col = 0 when in_text = 0.
- Delay line: in_text, col and every vga_in field are shifted through ROM_LATENCY registers, so they reach the select stage in the same cycle as the matching char_pixels.
- Select stage: bit = char_pixels[7 - col_d]. Then, registered:
  - vga_out.rgb = TEXT_COLOR if in_text_d & bit & !hblnk_d & !vblnk_d; otherwise rgb_d.
  - All other vga_out fields = their delayed values.
- Total latency vga_in -> vga_out = ROM_LATENCY+1 cycles, fixed, with no bubbles.
- Blanking: during hblnk or vblnk, rgb passes through unchanged (upstream drives 0). The overlay is never applied.
- Wrap-around: hcount/vcount rollover needs no special handling. Delayed counters are exact copies, so sync pulses keep their relative position.
- Reset mid-frame: the output is zeroed immediately. After release, the stream resumes aligned to whatever vga_in carries; no frame resync is attempted.
- char_pixels is ignored whenever in_text_d = 0; a nonzero ROM row at address 0 must not leak into the image.

Decomposition:
- vga_pkg gains the shared constants used by both this block and the char_addr generator:
  - LETTER_X_MIN/MAX, LETTER_Y_TOP/BOT ranges
  - NUM_X_LEFT/RIGHT, NUM_Y_MIN/MAX
  - GLYPH_W = 8
- Sub-module delay_vga: a parameterised N-stage register chain over the vga_if fields plus a user field, with async active-low reset. It is used for both the timing path and the in_text/col path.

Test Plan:
- Reset: hold rst=0 with random vga_in -> all vga_out = 0. Release rst -> the first vga_out equals the vga_in sampled 2 cycles earlier (ROM_LATENCY=1).
- Letter glyph: drive hcount 284..291 at vcount 110 with ROM model returning 8'b1000_0001 -> vga_out.rgb = TEXT_COLOR for hcount 284 and 291 only, observed 2 cycles later; columns 285..290 show upstream rgb.
- Number field edge: hcount 236..244 at vcount 154 with char_pixels = 8'hFF -> hcount 236..243 get TEXT_COLOR; hcount 244 (column 8) passes upstream rgb.
- Out-of-region: hcount 300, vcount 300, char_pixels = 8'hFF -> rgb unchanged, no overlay.
- Blanking: in_text true but hblnk = 1, char_pixels = 8'hFF -> vga_out.rgb = upstream rgb; hsync/vsync match the 2-cycle-delayed inputs.
- Latency sweep: ROM_LATENCY = 3 with a 3-cycle ROM model, full 1024x768 frame -> vga_out = vga_in delayed 4 cycles everywhere except glyph pixels. Glyph pixels match a golden bitmap exactly, with no column shift.
